// File: rtl/kbd_pkg.sv
// kbd_pkg: register map and field positions shared by the keypad key buffer.
// Rev 1.0
`default_nettype none

package kbd_pkg;

    localparam logic [2:0] KBD_DATA   = 3'b000;
    localparam logic [2:0] KBD_STATUS = 3'b010;
    localparam logic [2:0] KBD_CTRL   = 3'b100;

    localparam int STAT_NEMPTY_BIT = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_CNT_LSB    = 4;

    localparam int CTRL_IRQEN_BIT  = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    localparam int DATA_VALID_BIT  = 15;

    function automatic logic [15:0] status_word(input logic [3:0] cnt,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       nempty);
        logic [15:0] w;
        w                      = '0;
        w[STAT_CNT_LSB +: 4]   = cnt;
        w[STAT_OVF_BIT]        = ovf;
        w[STAT_FULL_BIT]       = full;
        w[STAT_NEMPTY_BIT]     = nempty;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_sync_fifo.sv
// kbd_sync_fifo: small synchronous FIFO of 4-bit key codes; full/empty derive from count.
// Rev 1.0
`default_nettype none

module kbd_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [3:0]    din_i,
    output logic [3:0]    dout_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/keyboard_key_buffer.sv
// keyboard_key_buffer: buffers keypad events and exposes DATA/STATUS/CTRL registers plus a level IRQ.
// Rev 1.0
`default_nettype none

module keyboard_key_buffer
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        kbd_ctrl,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [2:0]  address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data_output,
    output logic        key_irq
);

    logic        rd_sel, wr_sel;
    logic        data_rd, stat_rd, ctrl_wr;
    logic        flush;
    logic        ovf_set;
    logic [3:0]  fifo_dout;
    logic [AW:0] fifo_count;
    logic [3:0]  count4;
    logic        fifo_full, fifo_empty;

    logic        overflow_q, overflow_d;
    logic        irq_en_q,   irq_en_d;
    logic        key_irq_q,  key_irq_d;
    logic [15:0] rdata_q,    rdata_d;

    assign rd_sel  = kbd_ctrl & read_enable;
    assign wr_sel  = kbd_ctrl & write_enable;
    assign data_rd = rd_sel & (address == KBD_DATA);
    assign stat_rd = rd_sel & (address == KBD_STATUS);
    assign ctrl_wr = wr_sel & (address == KBD_CTRL);
    assign flush   = ctrl_wr & write_data[CTRL_FLUSH_BIT];
    assign count4  = 4'(fifo_count);

    // Full implies non-empty, so any DATA read pops and makes room for the push.
    assign ovf_set = key_valid & fifo_full & ~data_rd & ~flush;

    kbd_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (key_valid),
        .pop_i   (data_rd),
        .flush_i (flush),
        .din_i   (key_code),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        rdata_d    = rdata_q;
        key_irq_d  = irq_en_q & ~fifo_empty;

        // A new overflow outranks the clear-on-read so the event is never lost.
        if (flush)        overflow_d = 1'b0;
        else if (ovf_set) overflow_d = 1'b1;
        else if (stat_rd) overflow_d = 1'b0;

        if (ctrl_wr) irq_en_d = write_data[CTRL_IRQEN_BIT];

        if (rd_sel) begin
            case (address)
                KBD_DATA: begin
                    rdata_d = '0;
                    if (!fifo_empty) begin
                        rdata_d[DATA_VALID_BIT] = 1'b1;
                        rdata_d[3:0]            = fifo_dout;
                    end
                end
                KBD_STATUS: rdata_d = status_word(count4, overflow_q | ovf_set,
                                                  fifo_full, ~fifo_empty);
                KBD_CTRL:   rdata_d = {15'd0, irq_en_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            key_irq_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            key_irq_q  <= key_irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign read_data_output = rdata_q;
    assign key_irq          = key_irq_q;

endmodule

`default_nettype wire

// File: tb/tb_keyboard_key_buffer.sv
// tb_keyboard_key_buffer: directed plus random stimulus scored against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_keyboard_key_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        kbd_ctrl = 1'b0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [2:0]  address = 3'b000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data_output;
    logic        key_irq;

    keyboard_key_buffer #(.DEPTH(8), .AW(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .kbd_ctrl         (kbd_ctrl),
        .read_enable      (read_enable),
        .write_enable     (write_enable),
        .address          (address),
        .write_data       (write_data),
        .read_data_output (read_data_output),
        .key_irq          (key_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: a plain queue of codes plus the visible register bits.
    int          mq[$];
    bit          m_ovf   = 1'b0;
    bit          m_irqen = 1'b0;
    bit          m_irq   = 1'b0;
    logic [15:0] m_rd    = 16'h0000;

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_irqen = 1'b0;
        m_irq   = 1'b0;
        m_rd    = 16'h0000;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit cs,
                              input bit re, input bit we, input logic [2:0] a,
                              input logic [15:0] wd);
        bit   rd, wr, pop, flush, ovfset;
        int   sz;
        exp_t e;
        rd     = cs && re;
        wr     = cs && we;
        sz     = mq.size();
        pop    = rd && (a == 3'b000) && (sz > 0);
        flush  = wr && (a == 3'b100) && wd[1];
        ovfset = kv && !flush && (sz == 8) && !pop;
        if (rd) begin
            case (a)
                3'b000:  m_rd = (sz > 0) ? 16'(32768 + mq[0]) : 16'h0000;
                3'b010:  m_rd = 16'(sz * 16 + ((m_ovf || ovfset) ? 4 : 0)
                                + ((sz == 8) ? 2 : 0) + ((sz > 0) ? 1 : 0));
                3'b100:  m_rd = {15'd0, m_irqen};
                default: m_rd = 16'h0000;
            endcase
        end
        m_irq = m_irqen && (sz > 0);
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (kv && mq.size() < 8) mq.push_back(int'(kc));
        if (flush)                      m_ovf = 1'b0;
        else if (ovfset)                m_ovf = 1'b1;
        else if (rd && a == 3'b010)     m_ovf = 1'b0;
        if (wr && a == 3'b100) m_irqen = wd[0];
        e.rd  = m_rd;
        e.irq = m_irq;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit kv, input logic [3:0] kc, input bit cs, input bit re,
                         input bit we, input logic [2:0] a, input logic [15:0] wd);
        @(negedge clock);
        key_valid    = kv;
        key_code     = kc;
        kbd_ctrl     = cs;
        read_enable  = re;
        write_enable = we;
        address      = a;
        write_data   = wd;
        @(posedge clock);
        model_step(kv, kc, cs, re, we, a, wd);
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000);
    endtask

    task automatic rd(input logic [2:0] a);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a, 16'h0000);
    endtask

    task automatic push(input logic [3:0] c);
        cycle(1'b1, c, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000);
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (read_data_output !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s read_data: got %h expected 0000", tag, read_data_output);
        end
        vectors++;
        if (key_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL %s key_irq: got %b expected 0", tag, key_irq);
        end
    endtask

    // Reset is dropped between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        @(negedge clock);
        key_valid = 1'b0; kbd_ctrl = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
        @(posedge clock);
        exp_q.delete();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (read_data_output !== e.rd) begin
                    miscompares++;
                    $display("FAIL read_data @%0t: got %h expected %h", $time, read_data_output, e.rd);
                end
                vectors++;
                if (key_irq !== e.irq) begin
                    miscompares++;
                    $display("FAIL key_irq @%0t: got %b expected %b", $time, key_irq, e.irq);
                end
            end
        end
    end

    initial begin : stimulus
        bit          kv, cs, re, we;
        logic [3:0]  kc;
        logic [2:0]  a;
        logic [15:0] wd;
        int          r;

        model_reset();
        #1;
        check_reset_outputs("power_on_reset");
        @(negedge clock);
        #1;
        reset = 1'b1;

        rd(3'b000); rd(3'b010); idle();

        push(4'h1); push(4'h2); push(4'h3);
        repeat (4) rd(3'b000);

        for (int i = 0; i < 9; i++) push(4'(i));
        rd(3'b010); rd(3'b010);
        repeat (8) rd(3'b000);

        for (int i = 0; i < 8; i++) push(4'(i + 8));
        cycle(1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0000);
        rd(3'b010);
        repeat (8) rd(3'b000);

        for (int i = 0; i < 8; i++) push(4'(i));
        cycle(1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 3'b010, 16'h0000);
        rd(3'b010); rd(3'b010);
        repeat (8) rd(3'b000);

        cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'b100, 16'h0001);
        push(4'hA); idle(); idle();
        rd(3'b000); idle(); idle(); rd(3'b100);

        for (int i = 0; i < 4; i++) push(4'(i + 4));
        cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 3'b100, 16'h0003);
        rd(3'b010); idle();
        push(4'h1); push(4'h2); push(4'h3); idle();
        do_reset();
        rd(3'b010); rd(3'b000);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            kv = ($urandom_range(0, 99) < ((i < 1000) ? 15 : 45));
            kc = 4'($urandom_range(0, 15));
            cs = ($urandom_range(0, 99) < 85);
            re = ($urandom_range(0, 99) < 35);
            we = ($urandom_range(0, 99) < 12);
            r  = $urandom_range(0, 7);
            a  = (r < 3) ? 3'b000 : (r < 5) ? 3'b010 : (r < 7) ? 3'b100
                                            : 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            if (a == 3'b100) wd[1] = ($urandom_range(0, 15) == 0);
            cycle(kv, kc, cs, re, we, a, wd);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        @(posedge clock);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
